uart_tx_framer: RTL and testbench
=================================

UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
- REQ-001 Parameter CLK_FREQ, default 100_000_000, system clock frequency in Hz.
- REQ-002 Parameter BAUD_RATE, default 9_600, line bit rate in bits/s.
- REQ-003 Parameter BIT_CYCLES, default CLK_FREQ/BAUD_RATE (10416), clock cycles per line bit.
- REQ-004 clk_fpga  input  1  single system clock; all logic on its rising edge.
- REQ-005 reset  input  1  synchronous, active-high reset.
- REQ-006 tx_data  input  8  byte to send; sampled only on handshake.
- REQ-007 tx_valid  input  1  upstream offers tx_data.
- REQ-008 tx_ready  output  1  block can accept a byte this cycle.
- REQ-009 TxD  output  1  serial line; idle high.
- REQ-010 tx_busy  output  1  high while a frame is on the line.

Function
- REQ-011 Handshake SHALL occur in any cycle where tx_valid && tx_ready; tx_data SHALL be captured into an internal shift register that cycle.
- REQ-012 tx_ready SHALL be high only in IDLE; tx_valid without tx_ready SHALL have no effect.
- REQ-013 The FSM SHALL have states IDLE, START, DATA, STOP (plus PARITY, see REQ-024); IDLE->START on handshake, START->DATA, DATA->STOP after 8th bit, STOP->IDLE.
- REQ-014 TxD SHALL drive 0 from the cycle after handshake; the start bit SHALL last exactly BIT_CYCLES cycles.
- REQ-015 Data bits SHALL go out LSB first, each held exactly BIT_CYCLES cycles.
- REQ-016 The stop bit SHALL be 1 for exactly BIT_CYCLES cycles; the cycle after it ends the FSM SHALL be in IDLE with tx_ready=1.
- REQ-017 The bit-period counter SHALL restart at 0 on handshake (not free-running); every bit boundary SHALL be exact, with no drift across a frame.
- REQ-018 Bit counter SHALL count 0..7 in DATA and clear on leaving DATA; no wrap beyond 7.
- REQ-019 Back-to-back: tx_valid held high SHALL yield frames separated by exactly one idle-high cycle (the IDLE handshake cycle).
- REQ-020 tx_busy SHALL equal !tx_ready at all times.
- REQ-021 tx_data changes after handshake SHALL NOT affect the frame in flight.

Reset
- REQ-022 On reset: state=IDLE, TxD=1, tx_ready=1 after reset releases (tx_ready=0 while reset high), tx_busy=0, counters=0.
- REQ-023 Reset asserted mid-frame SHALL abort the frame; TxD SHALL be 1 on the cycle after the reset edge; no partial byte is resumed.

Configuration
- REQ-024 With UART_TX_PARITY_EN defined: PARITY state between DATA and STOP, transmits even parity (XOR of 8 data bits) for BIT_CYCLES cycles; frame = 11 bits.
- REQ-025 Without UART_TX_PARITY_EN: no PARITY state, DATA->STOP directly; frame = 10 bits; no parity logic synthesised.

Structure
- REQ-026 Shared package uart_pkg SHALL hold the FSM state encoding, default CLK_FREQ/BAUD_RATE constants and frame-length constants (10/11 bits), shared with the receiver.
- REQ-027 One sub-module uart_baud_tick SHALL generate a one-cycle tick every BIT_CYCLES cycles with a synchronous restart input driven on handshake.

Verification
- REQ-028 Reset, then idle 100 cycles -> TxD=1, tx_ready=1, tx_busy=0 throughout.
- REQ-029 Send 0x55 -> TxD sequence 0,1,0,1,0,1,0,1,0,1 (start, LSB first, stop), each segment exactly 10416 cycles; tx_ready low for 104160 cycles.
- REQ-030 tx_valid held with 0xA5 then 0x3C -> two frames, exactly one idle-high cycle between stop bit of first and start bit of second; receiver loopback yields 0xA5, 0x3C.
- REQ-031 Send 0x80, change tx_data to 0xFF one cycle after handshake -> line carries 0x80.
- REQ-032 Reset asserted at cycle 50000 of a frame -> TxD=1 next cycle, tx_ready=1 after release, new byte 0x0F then sent intact.
- REQ-033 With UART_TX_PARITY_EN, send 0x07 -> parity bit 1 (three ones), frame 11 bits, 114576 cycles; send 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions (state encoding, default rates, frame lengths) for the TX framer and the receiver.
// Build option UART_TX_PARITY_EN adds the PARITY state and selects the 11-bit frame length.
package uart_pkg;

  localparam int CLK_FREQ_DEFAULT     = 100_000_000;
  localparam int BAUD_RATE_DEFAULT    = 9_600;
  localparam int FRAME_BITS_NO_PARITY = 10;
  localparam int FRAME_BITS_PARITY    = 11;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = FRAME_BITS_PARITY;
`else
  localparam int FRAME_BITS = FRAME_BITS_NO_PARITY;
`endif

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } uart_state_t;

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_tx_framer_if.sv
// Byte handshake between an upstream producer (master) and the UART TX framer (slave).
interface uart_tx_framer_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: one-cycle tick every BIT_CYCLES cycles, restartable so a frame starts on a clean period.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int BIT_CYCLES = CLK_FREQ_DEFAULT / BAUD_RATE_DEFAULT
) (
  input  logic clk_fpga,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int            CW   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] count;

  // Restart lands count at 0 on the first cycle of the start bit, so the tick marks the last cycle of each bit
  always_ff @(posedge clk_fpga) begin
    if (reset || restart || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, 8 data bits LSB first, optional even parity, stop bit.
// Define UART_TX_PARITY_EN to insert the parity bit (11-bit frame); default build sends 10-bit frames.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = CLK_FREQ_DEFAULT,
  parameter int BAUD_RATE  = BAUD_RATE_DEFAULT,
  parameter int BIT_CYCLES = CLK_FREQ / BAUD_RATE
) (
  input  logic                   clk_fpga,
  input  logic                   reset,
  uart_tx_framer_if.slave        bus,
  output logic                   TxD,
  output logic                   tx_busy
);

  uart_state_t state;
  logic [7:0]  shift_reg;
  logic [2:0]  bit_cnt;
  logic        txd_q;
  logic        ready_q;
  logic        handshake;
  logic        bit_tick;
`ifdef UART_TX_PARITY_EN
  logic        parity_q;
`endif

  assign handshake    = bus.tx_valid && ready_q;
  assign bus.tx_ready = ready_q;
  assign tx_busy      = ~ready_q;
  assign TxD          = txd_q;

  uart_baud_tick #(.BIT_CYCLES(BIT_CYCLES)) u_baud_tick (
    .clk_fpga (clk_fpga),
    .reset    (reset),
    .restart  (handshake),
    .tick     (bit_tick)
  );

  // ready_q stays low through reset and rises on the first cycle after release
  always_ff @(posedge clk_fpga) begin
    if (reset) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      txd_q     <= 1'b1;
      ready_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      unique case (state)
        ST_IDLE: begin
          txd_q   <= 1'b1;
          ready_q <= 1'b1;
          if (handshake) begin
            shift_reg <= bus.tx_data;
            state     <= ST_START;
            ready_q   <= 1'b0;
            txd_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= even_parity(bus.tx_data);
`endif
          end
        end
        ST_START: begin
          if (bit_tick) begin
            state     <= ST_DATA;
            bit_cnt   <= '0;
            txd_q     <= shift_reg[0];
            shift_reg <= {1'b0, shift_reg[7:1]};
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              state   <= ST_PARITY;
              txd_q   <= parity_q;
`else
              state   <= ST_STOP;
              txd_q   <= 1'b1;
`endif
            end else begin
              bit_cnt   <= bit_cnt + 3'd1;
              txd_q     <= shift_reg[0];
              shift_reg <= {1'b0, shift_reg[7:1]};
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_tick) begin
            state <= ST_STOP;
            txd_q <= 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (bit_tick) begin
            state   <= ST_IDLE;
            ready_q <= 1'b1;
            txd_q   <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          ready_q <= 1'b1;
          txd_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Self-checking bench for uart_tx_framer: directed frames plus random bytes against a slot-based line model.
// Honours UART_TX_PARITY_EN the same way as the design (11-bit frames when defined).
module tb_uart_tx_framer;
  import uart_pkg::*;

  localparam int BC = 7;
  localparam int FB = FRAME_BITS;

  logic clk_fpga = 1'b0;
  logic reset;
  logic TxD;
  logic tx_busy;
  logic tx_ready;
  logic last_parity;

  int checks = 0;
  int errors = 0;

  always #5 clk_fpga = ~clk_fpga;

  uart_tx_framer_if bus ();

  assign tx_ready = bus.tx_ready;

  uart_tx_framer #(.BIT_CYCLES(BC)) dut (
    .clk_fpga (clk_fpga),
    .reset    (reset),
    .bus      (bus),
    .TxD      (TxD),
    .tx_busy  (tx_busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h at t=%0t", tag, observed, expected, $time);
    end
  endtask

  // Line level expected on the given cycle after the handshake cycle: slot 0 start, slots 1..8 data LSB first
  function automatic logic modelLine(input logic [7:0] d, input int cyc);
    int slot;
    slot = cyc / BC;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return d[3'(slot - 1)];
    if (FB == 11 && slot == 9) return ^d;
    return 1'b1;
  endfunction

  // Called at the negedge of the intended handshake cycle; returns at the negedge of the first cycle after the stop bit
  task automatic applyStimulus(input logic [7:0] data, input logic [7:0] post_data, input bit keep_valid);
    logic       obs_q[$];
    logic [7:0] rx;
    bus.tx_data  = data;
    bus.tx_valid = 1'b1;
    checkOutput("hs_ready", {31'd0, tx_ready}, 32'd1);
    for (int i = 0; i < FB * BC; i++) begin
      @(negedge clk_fpga);
      if (i == 0) begin
        bus.tx_data  = post_data;
        bus.tx_valid = keep_valid;
      end
      obs_q.push_back(TxD);
      checkOutput("txd_frame", {31'd0, TxD}, {31'd0, modelLine(data, i)});
      checkOutput("ready_busy_frame", {30'd0, tx_ready, tx_busy}, 32'd1);
    end
    for (int b = 0; b < 8; b++) rx[3'(b)] = obs_q[(b + 1) * BC + BC / 2];
    checkOutput("loopback_byte", {24'd0, rx}, {24'd0, data});
    if (FB == 11) last_parity = obs_q[9 * BC + BC / 2];
    @(negedge clk_fpga);
    checkOutput("end_idle", {29'd0, tx_ready, tx_busy, TxD}, 32'd5);
  endtask

  task automatic abortFrame();
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b1;
    checkOutput("abort_hs_ready", {31'd0, tx_ready}, 32'd1);
    for (int i = 0; i < 4 * BC + 3; i++) begin
      @(negedge clk_fpga);
      if (i == 0) bus.tx_valid = 1'b0;
      checkOutput("abort_txd_pre", {31'd0, TxD}, {31'd0, modelLine(8'h00, i)});
    end
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk_fpga);
      checkOutput("abort_in_reset", {30'd0, tx_ready, TxD}, 32'd1);
    end
    reset = 1'b0;
    @(negedge clk_fpga);
    checkOutput("abort_release", {29'd0, tx_ready, tx_busy, TxD}, 32'd5);
  endtask

  initial begin
    logic [7:0] cur;
    logic [7:0] nxt;
    bit         kv;
    int         gap;

    reset        = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    last_parity  = 1'b0;

    repeat (3) begin
      @(negedge clk_fpga);
      checkOutput("reset_hold", {30'd0, tx_ready, TxD}, 32'd1);
    end
    reset = 1'b0;
    @(negedge clk_fpga);
    for (int i = 0; i < 100; i++) begin
      checkOutput("idle_after_reset", {29'd0, tx_ready, tx_busy, TxD}, 32'd5);
      @(negedge clk_fpga);
    end

    applyStimulus(8'h55, 8'h00, 1'b0);
    applyStimulus(8'hA5, 8'h3C, 1'b1);
    applyStimulus(8'h3C, 8'h00, 1'b0);
    applyStimulus(8'h80, 8'hFF, 1'b0);

    abortFrame();
    applyStimulus(8'h0F, 8'h00, 1'b0);

`ifdef UART_TX_PARITY_EN
    applyStimulus(8'h07, 8'h00, 1'b0);
    checkOutput("parity_07", {31'd0, last_parity}, 32'd1);
    applyStimulus(8'h03, 8'h00, 1'b0);
    checkOutput("parity_03", {31'd0, last_parity}, 32'd0);
`endif

    cur = 8'($urandom);
    for (int n = 0; n < 16; n++) begin
      nxt = 8'($urandom);
      kv  = 1'($urandom_range(0, 1));
      applyStimulus(cur, kv ? nxt : 8'($urandom), kv);
      if (!kv) begin
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) begin
          @(negedge clk_fpga);
          checkOutput("idle_gap", {29'd0, tx_ready, tx_busy, TxD}, 32'd5);
        end
      end
      cur = nxt;
    end
    bus.tx_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
